svc_rv_stage_wb_q: RTL and testbench

Parametrised RISC-V write-back/retire stage for the svc_rv pipeline. It selects the final rd value from N result sources and drives it combinationally to the ID-stage register file. Accepted instructions go into a DEPTH-entry retire queue, and it counts retired instructions. It also latches a halt condition on EBREAK or trap so the core stops issuing into retire while the queue drains.

---
 rtl/svc_rv_stage_wb_q.sv | 129 ++++++++++++
 tb/tb_svc_rv_stage_wb_q.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/svc_rv_stage_wb_q.sv
// Write-back/retire stage: result select to the register file, a DEPTH-entry
// retire queue, a retired-instruction counter and a halt latch for EBREAK/trap.
module svc_rv_stage_wb_q #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int NSRC  = 6,
    localparam int SRC_W = $clog2(NSRC)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [SRC_W-1:0]       res_src_wb,
    input  logic [NSRC*XLEN-1:0]   src_data_wb,
    input  logic [31:0]            instr_wb,
    input  logic [XLEN-1:0]        pc_plus4_wb,
    input  logic [XLEN-1:0]        rs1_data_wb,
    input  logic [XLEN-1:0]        rs2_data_wb,
    input  logic                   trap_wb,
    input  logic [1:0]             trap_code_wb,
    input  logic                   reg_write_wb,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [XLEN-1:0]        rd_data_wb,
    output logic                   rd_we_wb,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [31:0]            instr_ret,
    output logic [XLEN-1:0]        pc_ret,
    output logic [XLEN-1:0]        rs1_data_ret,
    output logic [XLEN-1:0]        rs2_data_ret,
    output logic [XLEN-1:0]        rd_data_ret,
    output logic                   trap_ret,
    output logic [1:0]             trap_code_ret,
    output logic                   reg_write_ret,
    output logic                   ebreak_ret,
    output logic                   halted,
    input  logic                   halt_clr,
    output logic [63:0]            instret
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_halted;
    logic [63:0]      r_instret;

    logic [31:0]      r_instr_q [DEPTH];
    logic [XLEN-1:0]  r_pc_q    [DEPTH];
    logic [XLEN-1:0]  r_rs1_q   [DEPTH];
    logic [XLEN-1:0]  r_rs2_q   [DEPTH];
    logic [XLEN-1:0]  r_rd_q    [DEPTH];
    logic             r_trap_q  [DEPTH];
    logic [1:0]       r_tcode_q [DEPTH];
    logic             r_rw_q    [DEPTH];
    logic             r_ebrk_q  [DEPTH];

    logic [XLEN-1:0]  w_rd_data;
    logic             w_accept, w_push, w_pop, w_ebreak, w_full;

    // Out-of-range selects fall through to the zero default.
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NSRC; i++)
            if (res_src_wb == SRC_W'(i)) w_rd_data = src_data_wb[i*XLEN +: XLEN];
    end

    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign s_ready  = !w_full && !r_halted;
    assign m_valid  = (r_count != '0);
    assign w_accept = s_valid && s_ready;
    assign w_push   = w_accept;
    assign w_pop    = m_valid && m_ready;
    assign w_ebreak = (instr_wb == 32'h0010_0073);

    assign rd_data_wb = w_rd_data;
    assign rd_we_wb   = w_accept && reg_write_wb && !trap_wb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_halted  <= 1'b0;
            r_instret <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
                r_instret <= r_instret + 64'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // A halting accept outranks a same-cycle clear.
            if (w_accept && (w_ebreak || trap_wb)) r_halted <= 1'b1;
            else if (halt_clr)                     r_halted <= 1'b0;
        end
    end

    // Payload storage carries no reset; m_valid gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr_q[r_wr_ptr] <= instr_wb;
            r_pc_q[r_wr_ptr]    <= pc_plus4_wb - XLEN'(4);
            r_rs1_q[r_wr_ptr]   <= rs1_data_wb;
            r_rs2_q[r_wr_ptr]   <= rs2_data_wb;
            r_rd_q[r_wr_ptr]    <= w_rd_data;
            r_trap_q[r_wr_ptr]  <= trap_wb;
            r_tcode_q[r_wr_ptr] <= trap_code_wb;
            r_rw_q[r_wr_ptr]    <= reg_write_wb;
            r_ebrk_q[r_wr_ptr]  <= w_ebreak;
        end
    end

    assign instr_ret     = m_valid ? r_instr_q[r_rd_ptr] : '0;
    assign pc_ret        = m_valid ? r_pc_q[r_rd_ptr]    : '0;
    assign rs1_data_ret  = m_valid ? r_rs1_q[r_rd_ptr]   : '0;
    assign rs2_data_ret  = m_valid ? r_rs2_q[r_rd_ptr]   : '0;
    assign rd_data_ret   = m_valid ? r_rd_q[r_rd_ptr]    : '0;
    assign trap_ret      = m_valid ? r_trap_q[r_rd_ptr]  : 1'b0;
    assign trap_code_ret = m_valid ? r_tcode_q[r_rd_ptr] : 2'b0;
    assign reg_write_ret = m_valid ? r_rw_q[r_rd_ptr]    : 1'b0;
    assign ebreak_ret    = m_valid ? r_ebrk_q[r_rd_ptr]  : 1'b0;

    assign halted  = r_halted;
    assign instret = r_instret;
endmodule

// File: tb/tb_svc_rv_stage_wb_q.sv
// Directed bench for svc_rv_stage_wb_q: result select, queue flow control,
// ordering, halt latch, trap and mid-run reset.
module tb_svc_rv_stage_wb_q;
    localparam int XLEN = 32, DEPTH = 4, NSRC = 6, SRC_W = 3;

    logic                 clk = 1'b0, rst_n = 1'b0;
    logic [SRC_W-1:0]     res_src_wb = '0;
    logic [NSRC*XLEN-1:0] src_data_wb = '0;
    logic [31:0]          instr_wb = '0;
    logic [XLEN-1:0]      pc_plus4_wb = '0, rs1_data_wb = '0, rs2_data_wb = '0;
    logic                 trap_wb = 1'b0, reg_write_wb = 1'b0, s_valid = 1'b0;
    logic [1:0]           trap_code_wb = '0;
    logic                 m_ready = 1'b0, halt_clr = 1'b0;
    logic                 s_ready, rd_we_wb, m_valid, trap_ret, reg_write_ret, ebreak_ret, halted;
    logic [XLEN-1:0]      rd_data_wb, pc_ret, rs1_data_ret, rs2_data_ret, rd_data_ret;
    logic [31:0]          instr_ret;
    logic [1:0]           trap_code_ret;
    logic [63:0]          instret;

    int vectors = 0, miscompares = 0;

    svc_rv_stage_wb_q #(.XLEN(XLEN), .DEPTH(DEPTH), .NSRC(NSRC)) dut (
        .clk(clk), .rst_n(rst_n), .res_src_wb(res_src_wb), .src_data_wb(src_data_wb),
        .instr_wb(instr_wb), .pc_plus4_wb(pc_plus4_wb), .rs1_data_wb(rs1_data_wb),
        .rs2_data_wb(rs2_data_wb), .trap_wb(trap_wb), .trap_code_wb(trap_code_wb),
        .reg_write_wb(reg_write_wb), .s_valid(s_valid), .s_ready(s_ready),
        .rd_data_wb(rd_data_wb), .rd_we_wb(rd_we_wb), .m_valid(m_valid), .m_ready(m_ready),
        .instr_ret(instr_ret), .pc_ret(pc_ret), .rs1_data_ret(rs1_data_ret),
        .rs2_data_ret(rs2_data_ret), .rd_data_ret(rd_data_ret), .trap_ret(trap_ret),
        .trap_code_ret(trap_code_ret), .reg_write_ret(reg_write_ret), .ebreak_ret(ebreak_ret),
        .halted(halted), .halt_clr(halt_clr), .instret(instret)
    );

    always #5 clk = ~clk;

    // Leaves the bench 2 time units after a rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        #1;
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL rst_m_valid got %b exp 0", m_valid); end
        vectors++; if (instret !== 64'd0) begin miscompares++; $display("FAIL rst_instret got %0d exp 0", instret); end
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL rst_halted got %b exp 0", halted); end
        vectors++; if (pc_ret !== 32'd0) begin miscompares++; $display("FAIL rst_pc_ret got %h exp 0", pc_ret); end
        rst_n = 1'b1;
        tick();
        vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL rst_s_ready got %b exp 1", s_ready); end
    endtask

    task automatic test_single();
        for (int i = 0; i < NSRC; i++) src_data_wb[i*XLEN +: XLEN] = 32'hA000_0000 + i;
        src_data_wb[2*XLEN +: XLEN] = 32'h0000_1234;
        res_src_wb = 3'd2; pc_plus4_wb = 32'h104; instr_wb = 32'h0000_0013;
        reg_write_wb = 1'b1; s_valid = 1'b1; m_ready = 1'b1;
        #1;
        vectors++; if (rd_data_wb !== 32'h1234) begin miscompares++; $display("FAIL single_rd_data_wb got %h exp 1234", rd_data_wb); end
        vectors++; if (rd_we_wb !== 1'b1) begin miscompares++; $display("FAIL single_rd_we got %b exp 1", rd_we_wb); end
        tick();
        s_valid = 1'b0;
        #1;
        vectors++; if (m_valid !== 1'b1) begin miscompares++; $display("FAIL single_m_valid got %b exp 1", m_valid); end
        vectors++; if (rd_data_ret !== 32'h1234) begin miscompares++; $display("FAIL single_rd_ret got %h exp 1234", rd_data_ret); end
        vectors++; if (pc_ret !== 32'h100) begin miscompares++; $display("FAIL single_pc_ret got %h exp 100", pc_ret); end
        vectors++; if (rd_we_wb !== 1'b0) begin miscompares++; $display("FAIL idle_rd_we got %b exp 0", rd_we_wb); end
        tick();
        vectors++; if (instret !== 64'd1) begin miscompares++; $display("FAIL single_instret got %0d exp 1", instret); end
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL single_drained got %b exp 0", m_valid); end
    endtask

    task automatic test_src_select();
        res_src_wb = 3'd7;
        #1;
        vectors++; if (rd_data_wb !== 32'd0) begin miscompares++; $display("FAIL src7_rd_data got %h exp 0", rd_data_wb); end
        res_src_wb = 3'd5;
        #1;
        vectors++; if (rd_data_wb !== 32'hA000_0005) begin miscompares++; $display("FAIL src5_rd_data got %h exp a0000005", rd_data_wb); end
        res_src_wb = 3'd0;
    endtask

    task automatic test_back_to_back();
        logic acc;
        m_ready = 1'b0; reg_write_wb = 1'b0;
        for (int k = 0; k < 5; k++) begin
            s_valid = 1'b1; pc_plus4_wb = 32'h204 + 32'(4*k); rs1_data_wb = 32'(k);
            #1;
            vectors++; if (s_ready !== (k < 4)) begin miscompares++; $display("FAIL fill_s_ready[%0d] got %b exp %b", k, s_ready, (k < 4)); end
            tick();
        end
        vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("FAIL full_s_ready got %b exp 0", s_ready); end
        vectors++; if (pc_ret !== 32'h200) begin miscompares++; $display("FAIL stall_pc_a got %h exp 200", pc_ret); end
        tick();
        vectors++; if (pc_ret !== 32'h200 || rs1_data_ret !== 32'd0) begin miscompares++; $display("FAIL stall_hold got %h/%h exp 200/0", pc_ret, rs1_data_ret); end
        m_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            #1;
            vectors++; if (pc_ret !== 32'h200 + 32'(4*j) || rs1_data_ret !== 32'(j)) begin miscompares++; $display("FAIL order[%0d] got %h/%h exp %h/%h", j, pc_ret, rs1_data_ret, 32'h200 + 32'(4*j), j); end
            acc = s_ready;
            tick();
            if (acc) s_valid = 1'b0;
        end
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drained got %b exp 0", m_valid); end
        vectors++; if (instret !== 64'd6) begin miscompares++; $display("FAIL b2b_instret got %0d exp 6", instret); end
    endtask

    task automatic test_halt();
        m_ready = 1'b0; instr_wb = 32'h0010_0073; pc_plus4_wb = 32'h304; s_valid = 1'b1;
        #1;
        vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL halt_pre_ready got %b exp 1", s_ready); end
        tick();
        s_valid = 1'b0;
        #1;
        vectors++; if (halted !== 1'b1 || s_ready !== 1'b0) begin miscompares++; $display("FAIL halt_set got %b/%b exp 1/0", halted, s_ready); end
        vectors++; if (ebreak_ret !== 1'b1 || pc_ret !== 32'h300) begin miscompares++; $display("FAIL halt_head got %b/%h exp 1/300", ebreak_ret, pc_ret); end
        m_ready = 1'b1;
        tick();
        vectors++; if (m_valid !== 1'b0 || halted !== 1'b1 || instret !== 64'd7) begin miscompares++; $display("FAIL halt_drain got %b/%b/%0d exp 0/1/7", m_valid, halted, instret); end
        halt_clr = 1'b1;
        tick();
        halt_clr = 1'b0;
        #1;
        vectors++; if (halted !== 1'b0 || s_ready !== 1'b1) begin miscompares++; $display("FAIL halt_clr got %b/%b exp 0/1", halted, s_ready); end
        pc_plus4_wb = 32'h314; s_valid = 1'b1; halt_clr = 1'b1;
        tick();
        s_valid = 1'b0; halt_clr = 1'b0;
        #1;
        vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL halt_set_wins got %b exp 1", halted); end
        halt_clr = 1'b1;
        tick();
        halt_clr = 1'b0;
        vectors++; if (halted !== 1'b0 || m_valid !== 1'b0 || instret !== 64'd8) begin miscompares++; $display("FAIL halt_final got %b/%b/%0d exp 0/0/8", halted, m_valid, instret); end
        instr_wb = 32'h0000_0013;
    endtask

    task automatic test_trap();
        m_ready = 1'b0; trap_wb = 1'b1; trap_code_wb = 2'd2; reg_write_wb = 1'b1;
        pc_plus4_wb = 32'h404; s_valid = 1'b1;
        #1;
        vectors++; if (rd_we_wb !== 1'b0) begin miscompares++; $display("FAIL trap_rd_we got %b exp 0", rd_we_wb); end
        tick();
        s_valid = 1'b0; trap_wb = 1'b0; trap_code_wb = 2'd0; reg_write_wb = 1'b0;
        #1;
        vectors++; if (trap_ret !== 1'b1 || trap_code_ret !== 2'd2 || reg_write_ret !== 1'b1) begin miscompares++; $display("FAIL trap_head got %b/%0d/%b exp 1/2/1", trap_ret, trap_code_ret, reg_write_ret); end
        vectors++; if (halted !== 1'b1 || ebreak_ret !== 1'b0) begin miscompares++; $display("FAIL trap_halt got %b/%b exp 1/0", halted, ebreak_ret); end
        m_ready = 1'b1; halt_clr = 1'b1;
        tick();
        halt_clr = 1'b0;
        vectors++; if (halted !== 1'b0 || m_valid !== 1'b0 || instret !== 64'd9) begin miscompares++; $display("FAIL trap_after got %b/%b/%0d exp 0/0/9", halted, m_valid, instret); end
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s_valid = 1'b1; pc_plus4_wb = 32'h504 + 32'(4*k); instr_wb = 32'h0000_0013 + 32'(k);
            tick();
        end
        s_valid = 1'b0;
        #1;
        vectors++; if (m_valid !== 1'b1 || pc_ret !== 32'h500) begin miscompares++; $display("FAIL mid_pre got %b/%h exp 1/500", m_valid, pc_ret); end
        rst_n = 1'b0;
        #1;
        vectors++; if (m_valid !== 1'b0 || pc_ret !== 32'd0 || instr_ret !== 32'd0 || rd_data_ret !== 32'd0) begin miscompares++; $display("FAIL mid_rst_ret got %b/%h/%h/%h exp all 0", m_valid, pc_ret, instr_ret, rd_data_ret); end
        vectors++; if (instret !== 64'd0) begin miscompares++; $display("FAIL mid_rst_instret got %0d exp 0", instret); end
        tick();
        rst_n = 1'b1;
        tick();
        pc_plus4_wb = 32'h604; rs1_data_wb = 32'h77; s_valid = 1'b1;
        #1;
        vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL mid_s_ready got %b exp 1", s_ready); end
        tick();
        s_valid = 1'b0;
        #1;
        vectors++; if (m_valid !== 1'b1 || pc_ret !== 32'h600 || rs1_data_ret !== 32'h77) begin miscompares++; $display("FAIL mid_first got %b/%h/%h exp 1/600/77", m_valid, pc_ret, rs1_data_ret); end
        m_ready = 1'b1;
        tick();
        vectors++; if (instret !== 64'd1 || m_valid !== 1'b0) begin miscompares++; $display("FAIL mid_retire got %0d/%b exp 1/0", instret, m_valid); end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_single();
        test_src_select();
        test_back_to_back();
        test_halt();
        test_trap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
